// File: rtl/branch_predictor_pkg.sv
// Shared constants for the IF-stage next-PC predictor.
// Latency: n/a (constants only).
// Backpressure: n/a.
package branch_predictor_pkg;

  localparam int BP_WORD_SIZE = 16;

  // 2-bit saturating counter encoding; MSB set means "predict taken".
  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_e;

  // Fresh entries start weakly not-taken so one taken outcome flips them.
  localparam bp_ctr_e BP_CTR_RST = BP_WNT;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state function (bp_sat_counter).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  // Step toward the observed outcome, holding at either end.
  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != BP_ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != BP_SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB next-PC predictor with per-entry 2-bit counters and resolve checking.
// Latency: lookup and miss detection combinational; table/counter updates visible next cycle.
// Backpressure: none; each resolve is consumed on the edge it is presented.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int WORD_SIZE = BP_WORD_SIZE,
  parameter int BTB_IDX   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc_IF,
  output logic [WORD_SIZE-1:0] predicted_pc,
  output logic                 predict_taken,
  input  logic                 resolve_valid,
  input  logic                 resolve_is_cond,
  input  logic                 resolve_is_jump,
  input  logic [WORD_SIZE-1:0] resolve_pc,
  input  logic                 resolve_taken,
  input  logic [WORD_SIZE-1:0] resolve_target,
  input  logic [WORD_SIZE-1:0] resolve_pred_pc,
  output logic                 i_branch_miss,
  output logic                 jump_miss,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [15:0]          mispredict_count
);

  localparam int ENTRIES = 1 << BTB_IDX;
  localparam int TAG_W   = WORD_SIZE - BTB_IDX;
  localparam logic [WORD_SIZE-1:0] PC_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [ENTRIES];
  logic [TAG_W-1:0]     tag_d [ENTRIES];
  logic [WORD_SIZE-1:0] tgt_q [ENTRIES];
  logic [WORD_SIZE-1:0] tgt_d [ENTRIES];
  logic [1:0]           ctr_q [ENTRIES];
  logic [1:0]           ctr_d [ENTRIES];
  logic [15:0]          cnt_q, cnt_d;

  logic [BTB_IDX-1:0]   if_idx, rs_idx;
  logic [TAG_W-1:0]     if_tag, rs_tag;
  logic                 if_hit, rs_hit;
  logic [WORD_SIZE-1:0] actual_next;
  logic                 miss;
  logic [1:0]           rs_ctr_nxt;

  assign if_idx = pc_IF[BTB_IDX-1:0];
  assign if_tag = pc_IF[WORD_SIZE-1:BTB_IDX];
  assign rs_idx = resolve_pc[BTB_IDX-1:0];
  assign rs_tag = resolve_pc[WORD_SIZE-1:BTB_IDX];

  // Fetch-side lookup against the registered table (pre-update contents).
  always_comb begin
    if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    predict_taken = if_hit && ctr_q[if_idx][1];
    predicted_pc  = predict_taken ? tgt_q[if_idx] : (pc_IF + PC_ONE);
  end

  // Resolve check: compare the real next PC with what fetch guessed.
  always_comb begin
    actual_next   = (resolve_is_jump || resolve_taken) ? resolve_target
                                                       : (resolve_pc + PC_ONE);
    miss          = resolve_valid && (resolve_is_jump || resolve_is_cond) &&
                    (actual_next != resolve_pred_pc);
    jump_miss     = miss && resolve_is_jump;
    i_branch_miss = miss && resolve_is_cond && !resolve_is_jump;
    redirect_pc   = actual_next;
    rs_hit        = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
  end

  bp_sat_counter u_sat_ctr (
    .ctr     (ctr_q[rs_idx]),
    .taken   (resolve_taken),
    .ctr_nxt (rs_ctr_nxt)
  );

  // Next-state for the table and the mispredict counter.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    cnt_d   = cnt_q;
    if (resolve_valid) begin
      if (resolve_is_jump) begin
        // Jumps are always taken: overwrite with a strongly-taken entry.
        valid_d[rs_idx] = 1'b1;
        tag_d[rs_idx]   = rs_tag;
        tgt_d[rs_idx]   = resolve_target;
        ctr_d[rs_idx]   = BP_ST;
      end else if (resolve_is_cond) begin
        if (rs_hit) begin
          ctr_d[rs_idx] = rs_ctr_nxt;
          if (resolve_taken) tgt_d[rs_idx] = resolve_target;
        end else if (resolve_taken) begin
          // Allocate on first taken outcome, evicting any aliasing entry.
          valid_d[rs_idx] = 1'b1;
          tag_d[rs_idx]   = rs_tag;
          tgt_d[rs_idx]   = resolve_target;
          ctr_d[rs_idx]   = BP_WT;
        end
      end
    end
    if (miss && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // State registers; reset clears the whole table at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= BP_CTR_RST;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= tag_d[i];
        tgt_q[i] <= tgt_d[i];
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor using an expected-value queue.
// Latency: checks combinational outputs mid-cycle, state effects one cycle later.
// Backpressure: n/a.
module tb_branch_predictor;

  logic        clk;
  logic        reset_n;
  logic [15:0] pc_IF;
  logic [15:0] predicted_pc;
  logic        predict_taken;
  logic        resolve_valid;
  logic        resolve_is_cond;
  logic        resolve_is_jump;
  logic [15:0] resolve_pc;
  logic        resolve_taken;
  logic [15:0] resolve_target;
  logic [15:0] resolve_pred_pc;
  logic        i_branch_miss;
  logic        jump_miss;
  logic [15:0] redirect_pc;
  logic [15:0] mispredict_count;

  branch_predictor #(.WORD_SIZE(16), .BTB_IDX(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pc_IF            (pc_IF),
    .predicted_pc     (predicted_pc),
    .predict_taken    (predict_taken),
    .resolve_valid    (resolve_valid),
    .resolve_is_cond  (resolve_is_cond),
    .resolve_is_jump  (resolve_is_jump),
    .resolve_pc       (resolve_pc),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .resolve_pred_pc  (resolve_pred_pc),
    .i_branch_miss    (i_branch_miss),
    .jump_miss        (jump_miss),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_PPC = 0;
  localparam int S_PT  = 1;
  localparam int S_JM  = 2;
  localparam int S_BM  = 3;
  localparam int S_RED = 4;
  localparam int S_CNT = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_PPC:   observe = predicted_pc;
      S_PT:    observe = {15'd0, predict_taken};
      S_JM:    observe = {15'd0, jump_miss};
      S_BM:    observe = {15'd0, i_branch_miss};
      S_RED:   observe = redirect_pc;
      default: observe = mispredict_count;
    endcase
  endfunction

  task automatic expect_o(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Compare all queued expectations mid-cycle, then advance to just past the next edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic is_cond, input logic is_jump, input logic [15:0] pc,
                         input logic taken, input logic [15:0] tgt, input logic [15:0] pred);
    resolve_valid   = 1'b1;
    resolve_is_cond = is_cond;
    resolve_is_jump = is_jump;
    resolve_pc      = pc;
    resolve_taken   = taken;
    resolve_target  = tgt;
    resolve_pred_pc = pred;
  endtask

  task automatic idle();
    resolve_valid   = 1'b0;
    resolve_is_cond = 1'b0;
    resolve_is_jump = 1'b0;
    resolve_taken   = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    pc_IF           = 16'h0010;
    resolve_pc      = 16'h0000;
    resolve_target  = 16'h0000;
    resolve_pred_pc = 16'h0000;
    idle();

    // Reset state and wraparound of the sequential PC.
    expect_o("rst_pt",  S_PT,  16'h0);
    expect_o("rst_ppc", S_PPC, 16'h0011);
    expect_o("rst_cnt", S_CNT, 16'h0);
    expect_o("rst_jm",  S_JM,  16'h0);
    expect_o("rst_bm",  S_BM,  16'h0);
    tick();
    pc_IF = 16'hFFFF;
    expect_o("wrap_ppc", S_PPC, 16'h0000);
    tick();
    reset_n = 1'b1;

    // JMP miss, then BTB hit next cycle.
    pc_IF = 16'h0012;
    resolve(1'b0, 1'b1, 16'h0012, 1'b0, 16'h0040, 16'h0013);
    expect_o("jmp_jm",   S_JM,  16'h1);
    expect_o("jmp_bm",   S_BM,  16'h0);
    expect_o("jmp_red",  S_RED, 16'h0040);
    expect_o("jmp_same", S_PPC, 16'h0013);
    tick();
    idle();
    expect_o("jmp_ppc", S_PPC, 16'h0040);
    expect_o("jmp_pt",  S_PT,  16'h1);
    expect_o("jmp_cnt", S_CNT, 16'h1);
    tick();

    // BEQ at 0x20: taken x3, then not-taken x3.
    resolve(1'b1, 1'b0, 16'h0020, 1'b1, 16'h0008, 16'h0021);
    expect_o("beq1_bm",  S_BM,  16'h1);
    expect_o("beq1_jm",  S_JM,  16'h0);
    expect_o("beq1_red", S_RED, 16'h0008);
    tick();
    pc_IF = 16'h0020;
    resolve(1'b1, 1'b0, 16'h0020, 1'b1, 16'h0008, 16'h0008);
    expect_o("beq2_ppc", S_PPC, 16'h0008);
    expect_o("beq2_bm",  S_BM,  16'h0);
    tick();
    expect_o("beq3_bm", S_BM, 16'h0);
    tick();
    resolve(1'b1, 1'b0, 16'h0020, 1'b0, 16'h0008, 16'h0008);
    expect_o("nt1_bm",  S_BM,  16'h1);
    expect_o("nt1_red", S_RED, 16'h0021);
    tick();
    idle();
    expect_o("nt1_ppc", S_PPC, 16'h0008);
    expect_o("nt1_pt",  S_PT,  16'h1);
    tick();
    resolve(1'b1, 1'b0, 16'h0020, 1'b0, 16'h0008, 16'h0008);
    tick();
    resolve(1'b1, 1'b0, 16'h0020, 1'b0, 16'h0008, 16'h0021);
    expect_o("nt3_bm", S_BM, 16'h0);
    tick();
    idle();
    expect_o("nt3_ppc", S_PPC, 16'h0021);
    expect_o("nt3_pt",  S_PT,  16'h0);
    expect_o("nt3_cnt", S_CNT, 16'h4);
    tick();

    // Aliasing at idx 5.
    resolve(1'b1, 1'b0, 16'h0025, 1'b1, 16'h0050, 16'h0026);
    tick();
    idle();
    pc_IF = 16'h0025;
    expect_o("alias_hit", S_PPC, 16'h0050);
    tick();
    pc_IF = 16'h0035;
    expect_o("alias_pt",  S_PT,  16'h0);
    expect_o("alias_ppc", S_PPC, 16'h0036);
    tick();

    // Same-cycle lookup and update at idx 2.
    pc_IF = 16'h0002;
    resolve(1'b0, 1'b1, 16'h0002, 1'b0, 16'h0077, 16'h0003);
    expect_o("same_old", S_PPC, 16'h0003);
    expect_o("same_pt",  S_PT,  16'h0);
    tick();
    idle();
    expect_o("same_new", S_PPC, 16'h0077);
    tick();

    // Non-control resolve: no miss, no count.
    resolve(1'b0, 1'b0, 16'h0030, 1'b1, 16'h0099, 16'h1234);
    expect_o("nc_jm", S_JM, 16'h0);
    expect_o("nc_bm", S_BM, 16'h0);
    tick();

    // Not-taken conditional miss allocates nothing.
    resolve(1'b1, 1'b0, 16'h0007, 1'b0, 16'h0030, 16'h0030);
    expect_o("ntm_bm",  S_BM,  16'h1);
    expect_o("ntm_red", S_RED, 16'h0008);
    tick();
    idle();
    pc_IF = 16'h0007;
    expect_o("ntm_ppc", S_PPC, 16'h0008);
    expect_o("ntm_pt",  S_PT,  16'h0);
    expect_o("ntm_cnt", S_CNT, 16'h7);
    tick();

    // Both kind flags: jump wins.
    resolve(1'b1, 1'b1, 16'h0009, 1'b0, 16'h0099, 16'h000A);
    expect_o("both_jm",  S_JM,  16'h1);
    expect_o("both_bm",  S_BM,  16'h0);
    expect_o("both_red", S_RED, 16'h0099);
    tick();

    // Reset mid-operation with an update in flight.
    pc_IF = 16'h0012;
    resolve(1'b0, 1'b1, 16'h000B, 1'b0, 16'h0066, 16'h000C);
    reset_n = 1'b0;
    expect_o("mrst_cnt", S_CNT, 16'h0);
    expect_o("mrst_ppc", S_PPC, 16'h0013);
    expect_o("mrst_pt",  S_PT,  16'h0);
    tick();
    idle();
    reset_n = 1'b1;
    pc_IF = 16'h000B;
    expect_o("mrst_drop", S_PPC, 16'h000C);
    tick();

    // Saturation of the mispredict counter.
    resolve(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0200, 16'h0101);
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    idle();
    expect_o("sat_edge", S_CNT, 16'hFFFF);
    tick();
    resolve(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0200, 16'h0101);
    for (int i = 0; i < 4465; i++) @(posedge clk);
    #1;
    idle();
    expect_o("sat_hold", S_CNT, 16'hFFFF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage next-PC predictor for the pipelined TSC CPU: a direct-mapped BTB with a 2-bit saturating counter per entry.
- Checks resolved control instructions from ID/EX against what was predicted for them at fetch.
- Drives `jump_miss` / `i_branch_miss` into the hazard control unit, plus the redirect PC for the PC mux.
- Sits directly upstream of the hazard control unit and beside the PC register.

Parameters:
- `WORD_SIZE`, 16: PC / target width in bits. PCs are word addresses.
- `BTB_IDX`, 4: index bits; 2^BTB_IDX entries. Tag width = `WORD_SIZE` - `BTB_IDX`.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `pc_IF`  in  WORD_SIZE  PC being fetched this cycle.
- `predicted_pc`  out  WORD_SIZE  predicted next fetch PC (combinational).
- `predict_taken`  out  1  BTB hit with counter in a taken state.
- `resolve_valid`  in  1  a control instruction resolves this cycle.
- `resolve_is_cond`  in  1  resolving instruction is BNE/BEQ/BGZ/BLZ.
- `resolve_is_jump`  in  1  resolving instruction is JMP/JAL/JPR/JRL.
- `resolve_pc`  in  WORD_SIZE  PC of the resolving instruction.
- `resolve_taken`  in  1  actual outcome; ignored for jumps, which are always taken.
- `resolve_target`  in  WORD_SIZE  actual taken target.
- `resolve_pred_pc`  in  WORD_SIZE  `predicted_pc` carried down the pipe with that instruction.
- `i_branch_miss`  out  1  conditional-branch misprediction (combinational).
- `jump_miss`  out  1  jump misprediction (combinational).
- `redirect_pc`  out  WORD_SIZE  correct next PC on a miss.
- `mispredict_count`  out  16  saturating misprediction counter.

Behaviour:
- Reset (asynchronous, `reset_n`=0):
  - all entries invalid, all counters 2'b01 (weakly not-taken), `mispredict_count`=0.
  - Combinational outputs follow their inputs against the cleared table.
  - Reset asserted mid-operation discards every in-flight update; no partial writes.
- Entry fields: valid, tag[`WORD_SIZE`-`BTB_IDX`], target[`WORD_SIZE`], ctr[2].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, zero latency):
  - idx = `pc_IF`[BTB_IDX-1:0]; hit = valid && tag == `pc_IF`[WORD_SIZE-1:BTB_IDX].
  - `predict_taken` = hit && ctr[1].
  - `predicted_pc` = `predict_taken` ? target : `pc_IF`+1, computed modulo 2^WORD_SIZE (16'hFFFF+1 = 0).
- Resolve (combinational):
  - actual_next = (`resolve_is_jump` || `resolve_taken`) ? `resolve_target` : `resolve_pc`+1.
  - miss = `resolve_valid` && actual_next != `resolve_pred_pc`.
  - `jump_miss` = miss && `resolve_is_jump`.
  - `i_branch_miss` = miss && `resolve_is_cond` && !`resolve_is_jump`. Jump has priority if both kind flags are set.
  - `redirect_pc` = actual_next (valid only while a miss is asserted).
  - If `resolve_valid` && !`resolve_is_cond` && !`resolve_is_jump`: no miss, no update.
- Update (rising edge, when `resolve_valid`), at idx/tag taken from `resolve_pc`:
  - Jump: write valid=1, tag, target=`resolve_target`, ctr=11 (overwrite).
  - Conditional, tag hit:
    - ctr saturating +1 if taken, -1 if not; 11+1 stays 11, 00-1 stays 00.
    - Target rewritten only when taken.
  - Conditional, miss, taken: allocate valid=1, tag, target, ctr=10 (replaces any aliasing entry).
  - Conditional, miss, not-taken: no write.
- Same-cycle lookup and update at the same idx: lookup returns pre-update contents; the new entry is visible from the next cycle.
- `mispredict_count` += 1 on each edge where miss=1; saturates at 16'hFFFF.
- Updates are not gated by stall: a resolve is presented exactly once by the pipeline.

Decomposition:
- Shared package (`constants.v`):
  - `WORD_SIZE`.
  - Counter encodings `BP_SNT`/`BP_WNT`/`BP_WT`/`BP_ST`.
  - Reset counter value.
- Sub-module `bp_sat_counter`: combinational 2-bit saturating next-state function (inputs ctr, taken). Reused by a future global-history predictor.

Test Plan:
- Reset, `pc_IF`=16'h0010 -> `predict_taken`=0, `predicted_pc`=16'h0011; `pc_IF`=16'hFFFF -> `predicted_pc`=16'h0000.
- Resolve JMP at pc 16'h0012, target 16'h0040, `resolve_pred_pc`=16'h0013:
  - same cycle: `jump_miss`=1, `i_branch_miss`=0, `redirect_pc`=16'h0040.
  - next cycle, `pc_IF`=16'h0012 -> `predicted_pc`=16'h0040.
- BEQ at 16'h0020, target 16'h0008, resolved taken 3 times:
  - 1st resolve: miss.
  - then entry ctr=10; 3rd resolve -> ctr=11.
  - one not-taken resolve -> ctr=10, still predicts 16'h0008.
  - two not-taken resolves -> predicts 16'h0021.
- Aliasing: BEQ 16'h0025 taken allocated, then `pc_IF`=16'h0035 (same idx 5, different tag) -> `predict_taken`=0, `predicted_pc`=16'h0036.
- Same-cycle lookup and update of idx 2 -> old prediction this cycle, new prediction next cycle. Assert `reset_n` low mid-run -> table cleared immediately and `mispredict_count`=0.
- Force 70000 mispredicts -> `mispredict_count` holds 16'hFFFF.
